serial_frame_tx: RTL
====================

# serial_frame_tx

Frame transmitter that converts a parallel data word into an asynchronous serial bit stream: start bit (0), data bits LSB first, optional parity bit, stop bit (1). It is the sending end of the serial link whose receiving side is a D-flip-flop shift-register deserializer in the same design. The block accepts words through a single-cycle valid/ready handshake and paces each bit with an internal clock divider.

## Interface
- DATA_WIDTH, 8, number of data bits per frame; must be at least 1.
- CLKS_PER_BIT, 4, Clock cycles each serial bit is held; must be at least 1.
- PARITY, 0, parity mode:
  - 0: none.
  - 1: even.
  - 2: odd.
- Clock  input  1  system clock; all state changes on the rising edge.
- Clear_bar  input  1  asynchronous, active-low reset.
- Data_in  input  DATA_WIDTH  word to transmit; sampled only on the capture edge.
- Load  input  1  request to send Data_in.
- Ready  output  1  block can accept a word (registered).
- Busy  output  1  a frame is in progress (registered; always the complement of Ready).
- Serial_out  output  1  serial line; idle level is 1 (registered).
- Done  output  1  one-cycle pulse marking frame completion (registered).

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset (Clear_bar=0, asynchronous, any state):
  - State goes to IDLE.
  - Serial_out=1, Ready=1, Busy=0, Done=0.
  - Shift register, bit counter and cycle counter are cleared.
- IDLE:
  - Serial_out=1.
  - If Load=1 and Ready=1 at a rising edge (the capture edge), Data_in is copied into the shift register.
  - On that edge: state goes to START, Serial_out=0, Ready=0, Busy=1, cycle counter=0.
  - The parity bit is computed from Data_in and registered on the capture edge.
- START: Serial_out is held at 0 for CLKS_PER_BIT cycles, then state goes to DATA with bit counter=0.
- DATA:
  - Serial_out equals shift register bit 0.
  - After each bit period the register shifts right by one and the bit counter increments.
  - After DATA_WIDTH bits, state goes to PARITY if PARITY is nonzero, otherwise to STOP.
- PARITY:
  - Serial_out is held at the parity bit for CLKS_PER_BIT cycles.
  - Even mode: XOR of the data bits. Odd mode: inverted XOR of the data bits.
  - Then state goes to STOP.
- STOP:
  - Serial_out is held at 1 for CLKS_PER_BIT cycles.
  - On the edge that ends the stop bit: state goes to IDLE, Ready=1, Busy=0, Done=1 for exactly one cycle.
- Load while Ready=0 is ignored. No queuing; the word is lost.
- Data_in changes after the capture edge do not affect the frame in progress.
- Cycle counter width is clog2(CLKS_PER_BIT), minimum 1 bit; it wraps to 0 at CLKS_PER_BIT-1. Bit counter width is clog2(DATA_WIDTH+1).
- PARITY values 3 and above behave as 0.

## Timing
- Latency: Serial_out falls on the capture edge itself; no extra pipeline cycle.
- Frame length is (1 + DATA_WIDTH + (PARITY?1:0) + 1) × CLKS_PER_BIT cycles, counted from the capture edge to the edge that raises Ready.
- Back-to-back frames:
  - Ready rises on the closing edge of a frame, so the earliest next capture is one edge later.
  - Between frames the line is idle (1) for at least one Clock cycle.
- Done and Ready rise on the same edge. Done falls on the following edge, even if a new Load is captured there.
- Clear_bar asserted mid-frame:
  - All outputs take their reset values immediately, without waiting for Clock.
  - The partial frame is abandoned and is not resumed after Clear_bar deasserts.
- Clear_bar deassertion: the first capture is possible on the first rising edge at which Clear_bar=1 and Load=1.

## Test plan
- Reset and idle:
  - Stimulus: Clear_bar=0 for 3 cycles, then release with Load=0 for 10 cycles.
  - Required: Serial_out=1, Ready=1, Busy=0, Done=0 throughout.
- Single frame, defaults:
  - Stimulus: Load=1 with Data_in=0xA5 for one cycle.
  - Required: Serial_out sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
  - Required: Ready=0 for exactly 40 cycles, then Done=1 for one cycle.
- Parity:
  - Stimulus: PARITY=1 with Data_in=0x07, then PARITY=2 with Data_in=0x07.
  - Required: parity bit is 1 for even and 0 for odd, placed after data bit 7. Frame is 44 cycles.
- Load ignored while busy:
  - Stimulus: send 0x3C; pulse Load with Data_in=0xFF at cycle 12 of the frame.
  - Required: line carries 0x3C only. Ready stays 0. No second frame follows.
- Back-to-back:
  - Stimulus: hold Load=1 with Data_in=0x00, then 0xFF.
  - Required: two complete frames separated by exactly one idle-1 cycle, with one Done pulse per frame.
- Reset mid-frame:
  - Stimulus: Clear_bar=0 during data bit 3 of 0x55, between Clock edges.
  - Required: Serial_out=1 and Ready=1 without a Clock edge. The next Load of 0x81 yields a complete, correct frame.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Asynchronous serial frame transmitter: start bit, LSB-first data, optional
// parity bit, stop bit, each held for CLKS_PER_BIT clocks.
module serial_frame_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0
) (
  input  logic                  Clock,
  input  logic                  Clear_bar,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  Load,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Serial_out,
  output logic                  Done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam bit PAR_EN = (PARITY == 1) || (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state, w_state;
  logic [DATA_WIDTH-1:0] r_shift, w_shift;
  logic [BW-1:0]         r_bitCnt, w_bitCnt;
  logic [CW-1:0]         r_cycCnt, w_cycCnt;
  logic                  r_parity, w_parity;
  logic                  r_serial, w_serial;
  logic                  r_ready, w_ready;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;

  logic                  w_cycEnd;
  logic                  w_parCalc;
  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_cycEnd  = (r_cycCnt == CYC_LAST);
  assign w_parCalc = (PARITY == 2) ? ~(^Data_in) : (^Data_in);
  assign w_shifted = r_shift >> 1;

  always_ff @(posedge Clock or negedge Clear_bar) begin
    if (!Clear_bar) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bitCnt <= '0;
      r_cycCnt <= '0;
      r_parity <= 1'b0;
      r_serial <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_shift  <= w_shift;
      r_bitCnt <= w_bitCnt;
      r_cycCnt <= w_cycCnt;
      r_parity <= w_parity;
      r_serial <= w_serial;
      r_ready  <= w_ready;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  // Outputs are registered, so each transition loads the level of the next bit.
  always_comb begin
    w_state  = r_state;
    w_shift  = r_shift;
    w_bitCnt = r_bitCnt;
    w_cycCnt = w_cycEnd ? '0 : r_cycCnt + 1'b1;
    w_parity = r_parity;
    w_serial = r_serial;
    w_ready  = r_ready;
    w_busy   = r_busy;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_serial = 1'b1;
        w_cycCnt = '0;
        if (Load && r_ready) begin
          w_state  = S_START;
          w_shift  = Data_in;
          w_parity = w_parCalc;
          w_serial = 1'b0;
          w_ready  = 1'b0;
          w_busy   = 1'b1;
        end
      end
      S_START: begin
        if (w_cycEnd) begin
          w_state  = S_DATA;
          w_bitCnt = '0;
          w_serial = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_cycEnd) begin
          w_shift  = w_shifted;
          w_bitCnt = r_bitCnt + 1'b1;
          if (r_bitCnt == BIT_LAST) begin
            if (PAR_EN) begin
              w_state  = S_PARITY;
              w_serial = r_parity;
            end else begin
              w_state  = S_STOP;
              w_serial = 1'b1;
            end
          end else begin
            w_serial = w_shifted[0];
          end
        end
      end
      S_PARITY: begin
        if (w_cycEnd) begin
          w_state  = S_STOP;
          w_serial = 1'b1;
        end
      end
      S_STOP: begin
        if (w_cycEnd) begin
          w_state  = S_IDLE;
          w_serial = 1'b1;
          w_ready  = 1'b1;
          w_busy   = 1'b0;
          w_done   = 1'b1;
        end
      end
      default: begin
        w_state  = S_IDLE;
        w_serial = 1'b1;
        w_ready  = 1'b1;
        w_busy   = 1'b0;
      end
    endcase
  end

  assign Ready      = r_ready;
  assign Busy       = r_busy;
  assign Serial_out = r_serial;
  assign Done       = r_done;

endmodule
